// File: rtl/cordic_req_arbiter.sv
// cordic_req_arbiter: shares one pipelined cosine CORDIC core between two
// requesters. Round-robin issue of at most one operand per cycle; since the
// core carries no valid, a latency-matched {valid,id} tag pipeline follows
// each operand and steers the result into that requester's result FIFO.
// Credit (in-flight + buffered < RFIFO_DEPTH) guarantees no result is lost.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req{0,1}_valid/ready/data     operand handshake (ready = grant)
//   rsp{0,1}_valid/ready/data     first-word-fall-through result FIFOs
//   cordic_dataa                  registered operand to the core
//   cordic_result                 core output, LATENCY edges after dataa
//   busy                          any op in flight or any result buffered

// Per-requester FWFT result FIFO. Pushes never overflow (credit upstream);
// a pop while empty is ignored.
module cordic_rsp_fifo #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [W-1:0]           push_data,
   input  logic                   pop,
   output logic                   valid,
   output logic [W-1:0]           data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          do_pop;

   assign valid  = (count != '0);
   assign data   = mem[rd_ptr];
   assign do_pop = pop & valid;

   // Storage is not reset; only pointers/count define contents.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   // Power-of-two depth: pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

module cordic_req_arbiter #(
   parameter int W           = 32,
   parameter int LATENCY     = 4,
   parameter int RFIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_data,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_data,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [W-1:0] rsp0_data,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [W-1:0] rsp1_data,
   output logic [W-1:0] cordic_dataa,
   input  logic [W-1:0] cordic_result,
   output logic         busy
);
   localparam int NREQ = 2;
   localparam int CW   = $clog2(RFIFO_DEPTH) + 1;

   logic [NREQ-1:0]         req_valid, rsp_ready, eligible, grant, credit;
   logic [NREQ-1:0]         push, fifo_vld;
   logic [NREQ-1:0][W-1:0]  rsp_data;
   logic [NREQ-1:0][CW-1:0] inflight, fifo_cnt;
   logic [NREQ-1:0][CW:0]   outstanding;
   logic                    rr;          // 1: requester 1 wins a tie
   logic                    issue, issue_id;
   logic [LATENCY-1:0]      vld_pipe, id_pipe;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};

   // Credit uses registered counts only: a same-cycle pop does not free a slot.
   always_comb begin
      eligible = req_valid & credit & {NREQ{~rst}};
      grant    = eligible;
      if (&eligible) grant = rr ? 2'b10 : 2'b01;
   end

   assign issue      = |grant;
   assign issue_id   = grant[1];
   assign req0_ready = grant[0];
   assign req1_ready = grant[1];

   // Operand register, rr pointer and tag pipeline. Stage LATENCY-1 lines up
   // with cordic_result carrying the matching result.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe     <= '0;
         id_pipe      <= '0;
         cordic_dataa <= '0;
         rr           <= 1'b0;
      end else begin
         vld_pipe[0] <= issue;
         id_pipe[0]  <= issue_id;
         for (int i = 1; i < LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            id_pipe[i]  <= id_pipe[i-1];
         end
         if (issue) begin
            cordic_dataa <= issue_id ? req1_data : req0_data;
            rr           <= ~issue_id;
         end
      end
   end

   genvar k;
   generate
      for (k = 0; k < NREQ; k++) begin : g_lane
         assign push[k]        = vld_pipe[LATENCY-1] & (id_pipe[LATENCY-1] == 1'(k));
         assign outstanding[k] = {1'b0, inflight[k]} + {1'b0, fifo_cnt[k]};
         assign credit[k]      = outstanding[k] < (CW+1)'(RFIFO_DEPTH);

         always_ff @(posedge clk) begin
            if (rst) inflight[k] <= '0;
            else begin
               case ({grant[k], push[k]})
                  2'b10:   inflight[k] <= inflight[k] + CW'(1);
                  2'b01:   inflight[k] <= inflight[k] - CW'(1);
                  default: inflight[k] <= inflight[k];
               endcase
            end
         end

         cordic_rsp_fifo #(.W(W), .DEPTH(RFIFO_DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[k]),
            .push_data (cordic_result),
            .pop       (rsp_ready[k]),
            .valid     (fifo_vld[k]),
            .data      (rsp_data[k]),
            .count     (fifo_cnt[k])
         );
      end
   endgenerate

   assign rsp0_valid = fifo_vld[0] & ~rst;
   assign rsp1_valid = fifo_vld[1] & ~rst;
   assign rsp0_data  = rsp_data[0];
   assign rsp1_data  = rsp_data[1];
   assign busy       = ~rst & ((|inflight[0]) | (|inflight[1]) | (|fifo_vld));
endmodule

// File: tb/tb_cordic_req_arbiter.sv
// Randomized bench for cordic_req_arbiter with a stub core
// (result = dataa + 1). The reference model tracks each requester's
// outstanding count, a list of in-flight results with due edges, and per-
// requester result queues; it predicts ready, rsp valid/data, busy and
// cordic_dataa every cycle.
module tb_cordic_req_arbiter;
   localparam int W     = 32;
   localparam int LAT   = 4;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [W-1:0] req0_data, req1_data;
   logic         rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [W-1:0] rsp0_data, rsp1_data;
   logic [W-1:0] cordic_dataa, cordic_result;
   logic         busy;

   always #5 clk = ~clk;

   // Stub core: result holds after LAT edges counting the edge that loads dataa.
   logic [W-1:0] core_pipe [LAT-1];
   always_ff @(posedge clk) begin
      core_pipe[0] <= cordic_dataa + 32'd1;
      for (int i = 1; i < LAT-1; i++) core_pipe[i] <= core_pipe[i-1];
   end
   assign cordic_result = core_pipe[LAT-2];

   cordic_req_arbiter #(.W(W), .LATENCY(LAT), .RFIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .req0_valid    (req0_valid),
      .req0_ready    (req0_ready),
      .req0_data     (req0_data),
      .req1_valid    (req1_valid),
      .req1_ready    (req1_ready),
      .req1_data     (req1_data),
      .rsp0_valid    (rsp0_valid),
      .rsp0_ready    (rsp0_ready),
      .rsp0_data     (rsp0_data),
      .rsp1_valid    (rsp1_valid),
      .rsp1_ready    (rsp1_ready),
      .rsp1_data     (rsp1_data),
      .cordic_dataa  (cordic_dataa),
      .cordic_result (cordic_result),
      .busy          (busy)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t got %h want %h", tag, $time, obs, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      int          due;
      bit          id;
      logic [31:0] val;
   } fl_t;

   fl_t         fl[$];
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   int          outst [2];
   bit          rr;
   int          ecnt;
   logic [31:0] exp_dataa;

   // Called between edges: compare outputs, then advance the model to the
   // state after the coming posedge.
   task automatic step();
      bit          el0, el1, g0, g1, p0, p1;
      logic [31:0] ov;
      ecnt++;
      if (rst) begin
         chk("rst_ready0", 32'(req0_ready), 0);
         chk("rst_ready1", 32'(req1_ready), 0);
         chk("rst_rsp0_valid", 32'(rsp0_valid), 0);
         chk("rst_rsp1_valid", 32'(rsp1_valid), 0);
         chk("rst_busy", 32'(busy), 0);
         fl.delete(); q0.delete(); q1.delete();
         outst[0] = 0; outst[1] = 0; rr = 1'b0; exp_dataa = '0;
         return;
      end
      el0 = req0_valid && (outst[0] < DEPTH);
      el1 = req1_valid && (outst[1] < DEPTH);
      if (el0 && el1) begin g0 = !rr; g1 = rr; end
      else begin g0 = el0; g1 = el1; end
      chk("ready0", 32'(req0_ready), 32'(g0));
      chk("ready1", 32'(req1_ready), 32'(g1));
      chk("rsp0_valid", 32'(rsp0_valid), 32'(q0.size() != 0));
      chk("rsp1_valid", 32'(rsp1_valid), 32'(q1.size() != 0));
      if (q0.size() != 0) chk("rsp0_data", rsp0_data, q0[0]);
      if (q1.size() != 0) chk("rsp1_data", rsp1_data, q1[0]);
      chk("busy", 32'(busy), 32'((outst[0] + outst[1]) != 0));
      chk("dataa", cordic_dataa, exp_dataa);
      // pops see the pre-edge FIFO contents
      p0 = rsp0_ready && (q0.size() != 0);
      p1 = rsp1_ready && (q1.size() != 0);
      if (p0) begin ov = q0.pop_front(); outst[0]--; end
      if (p1) begin ov = q1.pop_front(); outst[1]--; end
      while (fl.size() != 0 && fl[0].due == ecnt) begin
         if (fl[0].id) q1.push_back(fl[0].val);
         else          q0.push_back(fl[0].val);
         fl.pop_front();
      end
      if (g0 || g1) begin
         ov = g1 ? req1_data : req0_data;
         fl.push_back('{due: ecnt + LAT, id: g1, val: ov + 32'd1});
         outst[g1 ? 1 : 0]++;
         rr = !g1;
         exp_dataa = ov;
      end
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
      rsp0_ready = 0; rsp1_ready = 0;
      ecnt = 0; rr = 0; outst[0] = 0; outst[1] = 0; exp_dataa = '0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         @(posedge clk); #1;
         rst       = (cyc < 3) || (cyc == 850);
         req0_data = $urandom;
         req1_data = $urandom;
         if (cyc < 30) begin
            // lone op with a known operand
            req0_valid = (cyc == 5);
            req1_valid = 1'b0;
            req0_data  = 32'h3F000000;
            rsp0_ready = (cyc > 20);
            rsp1_ready = 1'b1;
         end else if (cyc < 400) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
         end else if (cyc < 700) begin
            // requester 0 backpressured: credit limits its accepts
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            rsp0_ready = (cyc >= 550) && ($urandom_range(0, 9) < 3);
            rsp1_ready = 1'b1;
         end else if (cyc < 1000) begin
            // full contention, mid-flight reset at 850
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            rsp0_ready = (cyc < 840) || (cyc > 860);
            rsp1_ready = (cyc < 840) || (cyc > 860);
         end else begin
            // mostly-full FIFOs: frequent push/pop on the same edge
            req0_valid = ($urandom_range(0, 9) < 6);
            req1_valid = ($urandom_range(0, 9) < 6);
            rsp0_ready = ($urandom_range(0, 4) == 0);
            rsp1_ready = ($urandom_range(0, 4) == 0);
         end
         @(negedge clk);
         step();
      end
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/cordic_req_arbiter.md
Name: cordic_req_arbiter

Overview:
- Shares one pipelined floating-point cosine CORDIC core between two requesters (e.g. two custom-instruction or DMA clients).
- Round-robin arbitration issues at most one operand per cycle into the core.
- The core has no valid signal, so the block tracks each operand's owner through a latency-matched tag pipeline.
- Results are steered into per-requester result FIFOs; credit-based admission means a result is never dropped.

Parameters:
W, 32, float operand/result width (IEEE-754 single)
LATENCY, 4, clk edges from cordic_dataa changing to cordic_result holding the matching result; must be >= 1
RFIFO_DEPTH, 4, entries per result FIFO; also the per-requester outstanding-operation limit; power of two, >= 2

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 operand valid
req0_ready  out  1  requester 0 operand accepted this cycle
req0_data  in  W  requester 0 float operand (angle, radians)
req1_valid  in  1  requester 1 operand valid
req1_ready  out  1  requester 1 operand accepted this cycle
req1_data  in  W  requester 1 float operand
rsp0_valid  out  1  requester 0 result available
rsp0_ready  in  1  requester 0 consumes result
rsp0_data  out  W  requester 0 float result
rsp1_valid  out  1  requester 1 result available
rsp1_ready  in  1  requester 1 consumes result
rsp1_data  out  W  requester 1 float result
cordic_dataa  out  W  registered operand to the CORDIC core
cordic_result  in  W  CORDIC core output
busy  out  1  any operation in flight or any result buffered

Behaviour:
- Reset (rst=1 at a posedge):
  - Clears tag pipeline, FIFO pointers/counts and in-flight counters; rr pointer -> 0 (req0 has priority).
  - cordic_dataa -> 0.
  - While rst=1: req*_ready=0, rsp*_valid=0, busy=0.
- Reset mid-operation: every in-flight and buffered result is discarded. The core may keep computing; nothing is captured.
- Credit:
  - outstanding_k = inflight_k + fifo_count_k.
  - credit_k = (outstanding_k < RFIFO_DEPTH).
  - A response pop in the same cycle does not count toward credit (credit uses registered counts).
- Arbitration (combinational):
  - eligible_k = reqk_valid & credit_k.
  - If both are eligible, grant the requester indicated by rr. Otherwise grant the single eligible one.
  - reqk_ready = grant_k.
  - ready depends combinationally on valid; requesters must not make valid depend on ready.
- Issue: on a posedge with grant_k:
  - cordic_dataa <= reqk_data; tag stage 0 <= {valid=1, id=k}; inflight_k increments; rr <= ~k.
  - With no grant: tag stage 0 valid <= 0, cordic_dataa holds its value, rr holds.
- Tag pipeline: LATENCY-deep shift register of {valid,id}, advancing every cycle.
- Capture: when the tag at stage LATENCY-1 is valid with id k, cordic_result is pushed into FIFO k on that posedge and inflight_k decrements.
- Accept-to-capture: accept at edge T -> cordic_dataa at T -> result pushed at edge T+LATENCY -> rsp valid from cycle T+LATENCY.
- Back-to-back issues, alternating or the same requester, sustain one accept per cycle.
- Result FIFOs:
  - First-word-fall-through: rspk_valid = !empty, rspk_data = head.
  - Pop on rspk_valid & rspk_ready.
  - Simultaneous push and pop: count unchanged; pointers wrap modulo RFIFO_DEPTH.
  - Overflow cannot occur because of credit; pop when empty is ignored.
- Ordering: results per requester return in issue order; no ordering between requesters.
- busy = |inflight_0 | |inflight_1 | !empty0 | !empty1.

Test Plan:
- Bench uses a stub core (result = dataa + 1, delayed LATENCY=4) unless noted.
- Single op: req0 data 0x3F000000 accepted at edge T -> rsp0_valid rises at T+4 with 0x3F000001; busy high from T to pop.
- Contention and fairness: both valid continuously, rsp*_ready=1 -> grants alternate 0,1,0,1,... (req0 first after reset); rsp0 gets 0x10,0x11,0x12 for inputs 0x0F,0x10,0x11 in order.
- Backpressure/credit: rsp0_ready=0, req0 always valid -> exactly 4 accepts, then req0_ready=0; req1 still accepted every cycle. One rsp0 pop -> exactly one more req0 accept.
- Simultaneous push/pop: a full FIFO0 is popped on the same edge as a new capture -> count stays 4, data order preserved across pointer wrap.
- Reset mid-flight: 3 ops in flight plus 2 buffered, rst pulsed one cycle -> rsp*_valid=0, busy=0, no spurious captures in the next 4 cycles; the next req1 op completes normally.
- Real core (LATENCY set to the core's measured depth): operand 0x00000000 -> result within ±4 ULP of 0x3F800000; operand 0x3FC90FDB (π/2) -> |result| < 1e-5.
